lsu: RTL and testbench

Load/store unit sitting directly downstream of the ALU in the execute stage. It takes the ALU result as the effective address, plus the store data and funct3 of a RV32I load/store. It then runs one data-memory transaction over a request/grant/response handshake, with variable memory latency. It returns a sign- or zero-extended load value and a fault flag, and holds `busy` so the pipeline stalls while the access is outstanding.

---
 rtl/lsu.sv | 144 ++++++++++++++
 tb/tb_lsu.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// lsu: RV32I load/store unit driving a req/gnt/rvalid data-memory port.
// Ports: start/mem_write/funct3/addr/wdata in; busy/done/err/rdata out;
//        mem_req/mem_we/mem_addr/mem_wdata/mem_be to memory;
//        mem_gnt/mem_rvalid/mem_rdata from memory.
module lsu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             fault;
    logic [3:0]       be_d;
    logic [WIDTH-1:0] wd_d;
    logic [1:0]       off_q;
    logic [2:0]       f3_q;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] ld_val;

    // Access decode: enables, lane-replicated data and fault detection.
    always_comb begin
        fault = 1'b0;
        be_d  = 4'b0000;
        wd_d  = wdata;
        case (funct3)
            3'b000: begin
                be_d = 4'b0001 << addr[1:0];
                wd_d = {4{wdata[7:0]}};
            end
            3'b001: begin
                be_d  = 4'b0011 << addr[1:0];
                wd_d  = {2{wdata[15:0]}};
                fault = addr[0];
            end
            3'b010: begin
                be_d  = 4'b1111;
                fault = |addr[1:0];
            end
            3'b100: begin
                be_d  = 4'b0001 << addr[1:0];
                fault = mem_write;
            end
            3'b101: begin
                be_d  = 4'b0011 << addr[1:0];
                fault = mem_write | addr[0];
            end
            default: fault = 1'b1;
        endcase
    end

    // Load extraction from the latched offset; funct3[2] selects unsigned.
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (f3_q[1:0])
            2'b00:   ld_val = {{24{shifted[7] & ~f3_q[2]}}, shifted[7:0]};
            2'b01:   ld_val = {{16{shifted[15] & ~f3_q[2]}}, shifted[15:0]};
            default: ld_val = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = fault ? RESP : REQ;
            REQ:  if (mem_gnt) state_n = mem_we ? RESP : WAIT;
            WAIT: if (mem_rvalid) state_n = RESP;
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == RESP);
        mem_req = (state == REQ);
    end

    // Request fields stay frozen from issue until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err       <= 1'b0;
            rdata     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
        end else begin
            if (state == IDLE && start) begin
                err <= fault;
                if (!fault) begin
                    mem_we    <= mem_write;
                    mem_addr  <= {addr[WIDTH-1:2], 2'b00};
                    mem_wdata <= wd_d;
                    mem_be    <= be_d;
                    off_q     <= addr[1:0];
                    f3_q      <= funct3;
                end
            end
            if (state == RESP) begin
                err <= 1'b0;
            end
            if (state == WAIT && mem_rvalid) begin
                rdata <= ld_val;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed test of lsu against a transaction-level model.
// Ports: none (drives clk/rst_n and a scripted memory responder).
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    lsu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        e_busy, e_done, e_err, e_req, e_we;
    logic [31:0] e_rdata, e_addr, e_wdata;
    logic [3:0]  e_be;
    bit          chk_on = 1'b0;

    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_be = '0;
    logic [31:0] m_rdata = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("err", err & done, e_err);
            check("rdata", rdata, e_rdata);
            check("mem_req", mem_req, e_req);
            if (e_req) begin
                check("mem_we", mem_we, e_we);
                check("mem_addr", mem_addr, e_addr);
                check("mem_wdata", mem_wdata, e_wdata);
                check("mem_be", mem_be, e_be);
            end
        end
    end

    function automatic int sz(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit access_ok(input bit we, input logic [2:0] f3,
                                     input logic [31:0] a);
        bit legal;
        if (we) legal = (f3 <= 3'd2);
        else legal = (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        if (!legal) return 1'b0;
        return (int'(a[1:0]) % sz(f3)) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3,
                                            input logic [31:0] a);
        int s = sz(f3);
        int o = int'(a[1:0]);
        return 4'(((1 << s) - 1) << o);
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] f3,
                                             input logic [31:0] wd);
        logic [31:0] r;
        int s = sz(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_ld(input logic [2:0] f3,
                                             input logic [31:0] word,
                                             input logic [1:0] off);
        int s = sz(f3);
        logic [31:0] mask;
        logic [31:0] v;
        mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
        v = (word >> (8 * int'(off))) & mask;
        if (!f3[2] && s < 4 && v[8*s-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_idle();
        e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_req = 1'b0;
        e_we = m_we; e_addr = m_addr; e_wdata = m_wdata; e_be = m_be;
        e_rdata = m_rdata;
    endtask

    task automatic set_active(input bit req);
        e_busy = 1'b1; e_done = 1'b0; e_err = 1'b0; e_req = req;
        e_we = m_we; e_addr = m_addr; e_wdata = m_wdata; e_be = m_be;
        e_rdata = m_rdata;
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the
    // following IDLE cycle.
    task automatic txn(input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] word, input int gw, input int rw,
                       input bit pulse);
        start = 1'b1; mem_write = we; funct3 = f3; addr = a; wdata = wd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        set_idle();
        chk_on = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (!access_ok(we, f3, a)) begin
            set_active(1'b0);
            e_done = 1'b1; e_err = 1'b1;
            @(posedge clk); #1;
            set_idle();
            return;
        end
        m_we = we;
        m_addr = {a[31:2], 2'b00};
        m_be = model_be(f3, a);
        m_wdata = model_wd(f3, wd);
        for (int g = 0; g <= gw; g++) begin
            set_active(1'b1);
            mem_gnt = (g == gw);
            mem_rvalid = 1'b1;
            mem_rdata = 32'h5A5A_5A5A;
            if (pulse && g == 1) begin
                start = 1'b1; mem_write = ~we; addr = 32'h0000_0555;
            end else begin
                start = 1'b0; mem_write = we; addr = a;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; mem_write = we; addr = a;
        mem_gnt = 1'b1;
        if (!we) begin
            for (int w = 0; w <= rw; w++) begin
                set_active(1'b0);
                mem_rvalid = (w == rw);
                mem_rdata = (w == rw) ? word : 32'hA5A5_A5A5;
                @(posedge clk); #1;
            end
            m_rdata = model_ld(f3, word, a[1:0]);
        end
        set_active(1'b0);
        e_done = 1'b1;
        e_rdata = m_rdata;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h3C3C_3C3C;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req", mem_req, 0);
        check("rst_rdata", rdata, 0);
        check("rst_be", mem_be, 0);
        rst_n = 1'b1;

        txn(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, '0, 0, 0, 1'b0);
        check("sw_addr", mem_addr, 32'h100);
        check("sw_be", mem_be, 4'hF);
        check("sw_rdata", rdata, 32'h0);

        txn(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, '0, 0, 0, 1'b0);
        check("sh_addr", mem_addr, 32'h200);
        check("sh_be", mem_be, 4'hC);
        check("sh_wdata", mem_wdata, 32'hABCD_ABCD);

        txn(1'b1, 3'b000, 32'h001, 32'h0000_00A5, '0, 1, 0, 1'b0);
        check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        check("sb_be", mem_be, 4'h2);

        txn(1'b0, 3'b000, 32'h103, '0, 32'h80FF_0000, 0, 0, 1'b0);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        txn(1'b0, 3'b100, 32'h103, '0, 32'h80FF_0000, 0, 0, 1'b0);
        check("lbu_rdata", rdata, 32'h0000_0080);
        txn(1'b0, 3'b101, 32'h102, '0, 32'h80FF_0000, 0, 0, 1'b0);
        check("lhu_rdata", rdata, 32'h0000_80FF);

        txn(1'b0, 3'b010, 32'h101, '0, '0, 0, 0, 1'b0);
        check("lw_mis_rdata", rdata, 32'h0000_80FF);
        txn(1'b0, 3'b011, 32'h100, '0, '0, 0, 0, 1'b0);
        txn(1'b1, 3'b011, 32'h100, 32'h1111_1111, '0, 0, 0, 1'b0);
        txn(1'b0, 3'b001, 32'h001, '0, '0, 0, 0, 1'b0);
        check("fault_rdata", rdata, 32'h0000_80FF);

        txn(1'b0, 3'b001, 32'h002, '0, 32'h8001_0000, 1, 2, 1'b0);
        check("lh_rdata", rdata, 32'hFFFF_8001);

        txn(1'b0, 3'b010, 32'h300, '0, 32'hCAFE_F00D, 3, 1, 1'b1);
        check("lw_slow_rdata", rdata, 32'hCAFE_F00D);
        check("lw_slow_addr", mem_addr, 32'h300);

        // Reset in WAIT.
        start = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        addr = 32'h400; wdata = '0;
        m_we = 1'b0; m_addr = 32'h400; m_be = 4'hF; m_wdata = '0;
        set_idle();
        @(posedge clk); #1;
        start = 1'b0; mem_gnt = 1'b1;
        set_active(1'b1);
        @(posedge clk); #1;
        chk_on = 1'b0;
        mem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_rdata", rdata, 0);
        check("arst_req", mem_req, 0);
        check("arst_we", mem_we, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_wdata", mem_wdata, 0);
        check("arst_be", mem_be, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_we = 1'b0; m_addr = '0; m_be = '0; m_wdata = '0; m_rdata = '0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        set_idle();
        chk_on = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check("post_rst_rdata", rdata, 32'h0);

        txn(1'b0, 3'b010, 32'h404, '0, 32'h0BAD_F00D, 0, 0, 1'b0);
        check("post_rst_lw", rdata, 32'h0BAD_F00D);

        @(posedge clk); #1;
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
